gat_bram_load_bridge: RTL
=========================

# gat_bram_load_bridge

Multi-channel bridge between the register-bank/AXI-BRAM-controller side and the GAT accelerator's on-chip BRAMs. It converts byte addresses to word addresses, registers the write path, and pipelines a shared read-back port with a matching valid. For every channel it counts accepted writes against a programmed expected count and raises that channel's load-done flag. It sits in front of the `gat_top` core in the block design and generalises the old fixed three-channel address-slicing wrapper to NUM_CH channels, adding load tracking and error detection.

## Interface
- NUM_CH, 4: number of BRAM load channels (H data, node info, weight, spare)
- DATA_W, 32: word width per channel
- WADDR_W, 18: word-address width per channel
- BOFS_W, 2: byte-offset bits stripped from host addresses (log2 of bytes per word)
- CNT_W, 20: load-counter width
- RD_LAT, 2: BRAM read latency in cycles, at least 1
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- ch_arm  in  NUM_CH  per-channel pulse: clear counter/flags, start a new load
- ch_expected  in  NUM_CH*CNT_W  writes required for done; sampled on arm
- host_en / host_we  in  NUM_CH each  host write strobe (write accepted when both are 1)
- host_addr  in  NUM_CH*(WADDR_W+BOFS_W)  byte address
- host_din  in  NUM_CH*DATA_W  write data
- bram_en / bram_we  out  NUM_CH each  registered write strobe to BRAM port A
- bram_addr  out  NUM_CH*WADDR_W  registered word address
- bram_din  out  NUM_CH*DATA_W  registered write data
- ch_done  out  NUM_CH  load complete (sticky until next arm)
- ch_err  out  NUM_CH  misaligned or overrun write seen (sticky until next arm)
- ch_count  out  NUM_CH*CNT_W  accepted-write counter
- all_done  out  1  AND of ch_done, registered
- rd_en  in  1  read request, one per cycle allowed
- rd_ch  in  $clog2(NUM_CH)  channel select
- rd_addr  in  WADDR_W+BOFS_W  byte address
- bram_rd_en  out  NUM_CH  one-hot registered read enable to port B
- bram_rd_addr  out  WADDR_W  registered word address (shared)
- bram_dout  in  NUM_CH*DATA_W  port-B data
- rd_data  out  DATA_W  read result
- rd_valid  out  1  rd_data valid strobe

## Operation
- Per-channel FSM with states IDLE, LOAD, DONE; reset enters IDLE.
- Arm, in any state: count=0, err=0, done=0, latch expected. Go to DONE if expected==0, otherwise LOAD.
- Write in LOAD with low BOFS_W address bits all zero: forward it, count+1. When count+1==expected, go to DONE and set done the following cycle.
- Misaligned write (any low bit set), in any state: not forwarded, not counted, err=1.
- Write in DONE or IDLE (overrun / unarmed): not forwarded, not counted, err=1.
- Arm and write in the same cycle: arm wins and the write is discarded silently.
- Counter never wraps. It can only reach expected, and reaching expected ends LOAD.
- Read path: word address = rd_addr[WADDR_W+BOFS_W-1:BOFS_W]; low bits are ignored for reads, with no error. Reads are independent of FSM state.
- Read pipeline carries the channel index alongside the request. rd_data = bram_dout slice of the carried channel.

## Timing
- Reset values: all outputs 0, all FSMs IDLE.
- Write forward latency is 1 cycle: host strobe in cycle N produces bram_en/we/addr/din in cycle N+1. Strobes deassert the cycle after.
- ch_count updates in N+1. ch_done rises in N+1 for the completing write. all_done rises one cycle after the last ch_done.
- ch_err sets in N+1.
- Read request in cycle N produces bram_rd_en/addr in N+1, bram_dout valid in N+1+RD_LAT, and rd_data/rd_valid registered in N+2+RD_LAT (total latency RD_LAT+2).
- Back-to-back reads are fully pipelined; rd_valid pulses once per request.
- Reset asserted mid-load: all state cleared immediately. In-flight reads are dropped and no rd_valid is issued afterwards.

## Test plan
- Arm ch0 with expected=3, write byte addrs 0x0,0x4,0x8 -> bram_addr 0,1,2 one cycle later; ch_count 1,2,3; ch_done=1 in the cycle after the third write; ch_err=0.
- Arm all 4 channels with expected=2, complete them in staggered order -> all_done rises exactly one cycle after the last ch_done.
- Write to ch1 at 0x6 during LOAD -> no bram_en, count unchanged, ch_err[1]=1. Re-arm -> ch_err[1]=0.
- ch2 in DONE, fourth write arrives -> no bram_en, ch_err[2]=1, ch_done stays 1. Arm with expected=0 -> ch_done=1 the next cycle.
- Arm and write on ch3 in the same cycle -> count=0, no bram_en.
- Read streak: rd_ch=1 at addrs 0x0,0x4 then rd_ch=2 at 0x10 on three consecutive cycles, with RD_LAT=2 -> rd_valid in cycles N+4..N+6 with the matching data, bram_rd_addr 0,1,4. Assert rst during the streak -> no further rd_valid.

Source files
------------

// File: rtl/gat_bram_load_bridge.sv
// gat_bram_load_bridge: host-to-BRAM write bridge with per-channel load
// tracking (done/error flags, write counters) and a shared pipelined read port.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   ch_arm, ch_expected       per-channel load start and target write count
//   host_en/we/addr/din       per-channel host write (byte addresses)
//   bram_en/we/addr/din       registered BRAM port-A writes (word addresses)
//   ch_done, ch_err, ch_count per-channel load status
//   all_done                  registered AND of ch_done
//   rd_en, rd_ch, rd_addr     shared read request (byte address)
//   bram_rd_en, bram_rd_addr  registered BRAM port-B read request
//   bram_dout                 BRAM port-B data, RD_LAT cycles after request
//   rd_data, rd_valid         registered read result
module gat_bram_load_bridge #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 32,
  parameter int WADDR_W = 18,
  parameter int BOFS_W  = 2,
  parameter int CNT_W   = 20,
  parameter int RD_LAT  = 2,
  localparam int AW     = WADDR_W + BOFS_W,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_arm,
  input  logic [NUM_CH*CNT_W-1:0]   ch_expected,
  input  logic [NUM_CH-1:0]         host_en,
  input  logic [NUM_CH-1:0]         host_we,
  input  logic [NUM_CH*AW-1:0]      host_addr,
  input  logic [NUM_CH*DATA_W-1:0]  host_din,
  output logic [NUM_CH-1:0]         bram_en,
  output logic [NUM_CH-1:0]         bram_we,
  output logic [NUM_CH*WADDR_W-1:0] bram_addr,
  output logic [NUM_CH*DATA_W-1:0]  bram_din,
  output logic [NUM_CH-1:0]         ch_done,
  output logic [NUM_CH-1:0]         ch_err,
  output logic [NUM_CH*CNT_W-1:0]   ch_count,
  output logic                      all_done,
  input  logic                      rd_en,
  input  logic [CH_W-1:0]           rd_ch,
  input  logic [AW-1:0]             rd_addr,
  output logic [NUM_CH-1:0]         bram_rd_en,
  output logic [WADDR_W-1:0]        bram_rd_addr,
  input  logic [NUM_CH*DATA_W-1:0]  bram_dout,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } st_e;

  // Per-channel load state
  st_e st_q [NUM_CH];
  st_e st_d [NUM_CH];

  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   exp_q, exp_d;
  logic [NUM_CH-1:0]              done_q, done_d;
  logic [NUM_CH-1:0]              err_q, err_d;
  logic                           all_done_q, all_done_d;

  // Registered write path
  logic [NUM_CH-1:0]              wen_q, wen_d;
  logic [NUM_CH-1:0][WADDR_W-1:0] waddr_q, waddr_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  wdin_q, wdin_d;

  // Read pipeline: stage 0 is the cycle bram_rd_en is presented,
  // stage RD_LAT is the cycle bram_dout holds the data.
  logic [RD_LAT:0]                vld_q, vld_d;
  logic [RD_LAT:0][CH_W-1:0]      chp_q, chp_d;
  logic [NUM_CH-1:0]              brd_en_q, brd_en_d;
  logic [WADDR_W-1:0]             brd_addr_q, brd_addr_d;
  logic [DATA_W-1:0]              rd_data_q, rd_data_d;
  logic                           rd_valid_q, rd_valid_d;

  logic [AW-1:0]                  ha;
  logic [CNT_W-1:0]               cnt_inc;
  logic [CNT_W-1:0]               exp_in;
  logic                           wr;
  logic [DATA_W-1:0]              rd_sel;

  // Byte-offset bits of the read address carry no meaning for reads
  logic                           rd_bofs_unused;
  assign rd_bofs_unused = ^rd_addr[BOFS_W-1:0];

  // Load tracking and write forwarding
  always_comb begin
    ha         = '0;
    cnt_inc    = '0;
    exp_in     = '0;
    wr         = 1'b0;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    done_d     = done_q;
    err_d      = err_q;
    wen_d      = '0;
    waddr_d    = waddr_q;
    wdin_d     = wdin_q;
    all_done_d = &done_q;
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c] = st_q[c];
      ha      = host_addr[c*AW +: AW];
      exp_in  = ch_expected[c*CNT_W +: CNT_W];
      cnt_inc = cnt_q[c] + CNT_W'(1);
      wr      = host_en[c] & host_we[c];
      if (ch_arm[c]) begin
        // Arm has priority; a same-cycle write is dropped silently
        cnt_d[c] = '0;
        err_d[c] = 1'b0;
        exp_d[c] = exp_in;
        if (exp_in == '0) begin
          done_d[c] = 1'b1;
          st_d[c]   = S_DONE;
        end else begin
          done_d[c] = 1'b0;
          st_d[c]   = S_LOAD;
        end
      end else if (wr) begin
        if (ha[BOFS_W-1:0] != '0) begin
          err_d[c] = 1'b1;
        end else if (st_q[c] == S_LOAD) begin
          wen_d[c]   = 1'b1;
          waddr_d[c] = ha[AW-1:BOFS_W];
          wdin_d[c]  = host_din[c*DATA_W +: DATA_W];
          cnt_d[c]   = cnt_inc;
          if (cnt_inc == exp_q[c]) begin
            done_d[c] = 1'b1;
            st_d[c]   = S_DONE;
          end
        end else begin
          // Overrun after DONE or write to an unarmed channel
          err_d[c] = 1'b1;
        end
      end
    end
  end

  // Read request and return pipeline
  always_comb begin
    vld_d    = '0;
    chp_d    = '0;
    brd_en_d = '0;
    rd_sel   = '0;
    vld_d[0] = rd_en;
    chp_d[0] = rd_ch;
    for (int i = 1; i <= RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      chp_d[i] = chp_q[i-1];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      brd_en_d[c] = rd_en && (rd_ch == CH_W'(c));
      if (chp_q[RD_LAT] == CH_W'(c)) begin
        rd_sel = bram_dout[c*DATA_W +: DATA_W];
      end
    end
    brd_addr_d = rd_en ? rd_addr[AW-1:BOFS_W] : brd_addr_q;
    rd_valid_d = vld_q[RD_LAT];
    rd_data_d  = vld_q[RD_LAT] ? rd_sel : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c] <= S_IDLE;
      end
      cnt_q      <= '0;
      exp_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      all_done_q <= 1'b0;
      wen_q      <= '0;
      waddr_q    <= '0;
      wdin_q     <= '0;
      vld_q      <= '0;
      chp_q      <= '0;
      brd_en_q   <= '0;
      brd_addr_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c] <= st_d[c];
      end
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      done_q     <= done_d;
      err_q      <= err_d;
      all_done_q <= all_done_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdin_q     <= wdin_d;
      vld_q      <= vld_d;
      chp_q      <= chp_d;
      brd_en_q   <= brd_en_d;
      brd_addr_q <= brd_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bram_en      = wen_q;
  assign bram_we      = wen_q;
  assign bram_addr    = waddr_q;
  assign bram_din     = wdin_q;
  assign ch_done      = done_q;
  assign ch_err       = err_q;
  assign ch_count     = cnt_q;
  assign all_done     = all_done_q;
  assign bram_rd_en   = brd_en_q;
  assign bram_rd_addr = brd_addr_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;

endmodule
